ncl_flag_unit: RTL and testbench
================================

Name: ncl_flag_unit

Overview:
- Parametrised successor of the 2-bit dual-rail ALU overflow detector.
- Takes W-bit dual-rail operands A, B and the adder/subtractor result.
- Produces dual-rail V/N/Z flags through a clocked single-stage NULL Convention Logic (NCL) wavefront register with a Ki/Ko handshake.
- Keeps a sticky overflow flag, a saturating overflow event counter and an illegal-code error.
- Sits between the NCL ALU datapath and the status/flag consumer.

Parameters:
- W, 8, operand/result width in logical bits.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- a_dr  in  2*W  operand A, dual-rail.
- b_dr  in  2*W  operand B, dual-rail.
- res_dr  in  2*W  ALU sum/difference, dual-rail.
- op_dr  in  4  two dual-rail bits: bit0 = sub (B inverted), bit1 = arith_en (overflow check enabled).
- ki  in  1  downstream request: 1 = ready for DATA, 0 = ready for NULL.
- clr  in  1  clears ovf_sticky and ovf_cnt.
- ko  out  1  upstream request: 1 = request DATA, 0 = request NULL.
- flags_dr  out  6  dual-rail flags: bit2 = V, bit1 = N, bit0 = Z.
- ovf_sticky  out  1  set by any captured V=1.
- ovf_cnt  out  CNT_W  saturating count of captured V=1 wavefronts.
- illegal_err  out  1  sticky; set by any 11 rail pair.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Dual-rail encoding: logical bit i occupies [2i+1] = true rail and [2i] = false rail.
  - 10 = logic 1; 01 = logic 0; 00 = NULL; 11 = illegal.
- Completeness:
  - DATA-complete: every pair of a_dr, b_dr, res_dr and op_dr is 01 or 10.
  - NULL-complete: every pair is 00.
- Flag function, evaluated on the captured DATA:
  - Bp = B XOR sub.
  - V = arith_en AND (A[W-1] == Bp[W-1]) AND (res[W-1] != A[W-1]).
  - N = res[W-1].
  - Z = (res == 0).
- Reset values:
  - state = S_DATA, ko = 1, flags_dr = all 00 (NULL).
  - ovf_sticky = 0, ovf_cnt = 0, illegal_err = 0.
- FSM, two states:
  - S_DATA (ko = 1):
    - If DATA-complete and ki = 1 on a clock edge: next cycle flags_dr shows the encoded V/N/Z, ko = 0, go to S_NULL.
    - Otherwise hold, with flags_dr at NULL.
  - S_NULL (ko = 0):
    - If NULL-complete and ki = 0: next cycle flags_dr = NULL, ko = 1, go to S_DATA.
    - Otherwise hold the DATA flags.
- Latency: one clock from qualifying edge to flags_dr/ko change. flags_dr never mixes DATA and NULL pairs.
- Partial wavefronts (some pairs NULL, some DATA) satisfy neither completeness test, so state holds.
- Illegal code:
  - Any 11 pair on any input, in any state, sets illegal_err on the next edge.
  - A wavefront containing 11 is never DATA-complete or NULL-complete, so no capture occurs.
  - illegal_err is cleared only by rst. clr does not affect it.
- Counter and sticky flag:
  - On the capture edge with V = 1: ovf_sticky <= 1 and ovf_cnt <= ovf_cnt + 1.
  - ovf_cnt saturates at 2^CNT_W-1 with no wrap.
  - clr = 1 clears both on the next edge.
  - clr and capture-with-V in the same cycle: clr wins (result 0/0).
- rst mid-operation: rst asserted in S_NULL returns to S_DATA with NULL outputs on the next edge, regardless of ki and inputs.
- ki is ignored except at the two transition conditions above.

Test Plan:
1. W=8, add (op: sub=0, arith_en=1), A=0x7F, B=0x01, res=0x80, ki=1 -> one cycle later flags V=1 N=1 Z=0 (flags_dr=101001), ko=0, ovf_cnt=1, ovf_sticky=1. Then all-NULL inputs with ki=0 -> flags_dr=000000, ko=1.
2. Sub, A=0x80, B=0x01, res=0x7F -> V=1 N=0 Z=0. Then sub, A=0x05, B=0x05, res=0x00 -> V=0 N=0 Z=1, ovf_cnt=1 after the second wavefront.
3. arith_en=0 with A=0x7F, B=0x01, res=0x80 -> V=0 N=1. Also: DATA-complete inputs with ki=0 for 5 cycles -> no capture, flags NULL, ko stays 1 until ki=1.
4. Partial wavefront: A and B DATA, res still NULL for 3 cycles -> no capture. Inject 11 on a_dr bit3 -> illegal_err=1 next cycle, no capture. clr pulse -> illegal_err stays 1.
5. CNT_W=2: four overflow wavefronts -> ovf_cnt = 1, 2, 3, 3 (saturated). clr coincident with a fifth V=1 capture -> ovf_cnt=0, ovf_sticky=0.
6. rst asserted while in S_NULL with DATA flags shown -> next cycle flags_dr=0, ko=1, ovf_cnt=0, illegal_err=0, state S_DATA.

Source files
------------

// File: rtl/ncl_flag_unit.sv
// ncl_flag_unit
//   Dual-rail V/N/Z flag generator for the NCL ALU datapath. Operands, result
//   and opcode arrive as dual-rail wavefronts. A single-stage wavefront
//   register captures DATA and releases NULL under a Ki/Ko handshake.
//   The unit also keeps a sticky overflow flag, a saturating overflow event
//   counter and a sticky illegal-code (11 rail pair) error.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   a_dr, b_dr    operands A and B, dual-rail (2*W)
//   res_dr        ALU sum/difference, dual-rail (2*W)
//   op_dr         {arith_en, sub} as two dual-rail bits
//   ki            downstream request: 1 = ready for DATA, 0 = ready for NULL
//   clr           clears ovf_sticky and ovf_cnt
//   ko            upstream request: 1 = request DATA, 0 = request NULL
//   flags_dr      dual-rail {V, N, Z}
//   ovf_sticky    set by any captured V=1
//   ovf_cnt       saturating count of captured V=1 wavefronts
//   illegal_err   sticky, set by any 11 rail pair; cleared only by rst
//
// Encoding: logical bit i uses [2i+1] as the true rail and [2i] as the false
// rail. 10 = 1, 01 = 0, 00 = NULL, 11 = illegal.
module ncl_flag_unit #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*W-1:0]   a_dr,
  input  logic [2*W-1:0]   b_dr,
  input  logic [2*W-1:0]   res_dr,
  input  logic [3:0]       op_dr,
  input  logic             ki,
  input  logic             clr,
  output logic             ko,
  output logic [5:0]       flags_dr,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             illegal_err
);

  // Rail pairs across all inputs: A, B, result (W each) plus two opcode bits.
  localparam int NP = 3*W + 2;

  typedef enum logic {S_DATA, S_NULL} state_t;

  state_t               state_q;
  logic                 ko_q;
  logic [5:0]           flags_q;
  logic                 sticky_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 sticky_d;
  logic                 ill_q;

  logic [2*NP-1:0]      all_dr;
  logic [NP-1:0]        pair_data;
  logic [NP-1:0]        pair_null;
  logic [NP-1:0]        pair_ill;
  logic [W-1:0]         res_true;

  logic data_complete;
  logic null_complete;
  logic any_ill;
  logic sub;
  logic arith_en;
  logic a_msb;
  logic bp_msb;
  logic res_msb;
  logic v_flag;
  logic n_flag;
  logic z_flag;
  logic capture;
  logic null_ret;

  assign all_dr = {op_dr, res_dr, b_dr, a_dr};

  // Per-pair classification. An 11 pair is neither DATA nor NULL, so it
  // automatically blocks both completeness tests.
  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_pair
      assign pair_data[gi] = all_dr[2*gi+1] ^ all_dr[2*gi];
      assign pair_null[gi] = ~(all_dr[2*gi+1] | all_dr[2*gi]);
      assign pair_ill[gi]  = all_dr[2*gi+1] & all_dr[2*gi];
    end
    for (genvar gi = 0; gi < W; gi++) begin : g_res
      assign res_true[gi] = res_dr[2*gi+1];
    end
  endgenerate

  assign data_complete = &pair_data;
  assign null_complete = &pair_null;
  assign any_ill       = |pair_ill;

  // On a DATA-complete wavefront the true rail alone carries the logic value.
  assign sub      = op_dr[1];
  assign arith_en = op_dr[3];
  assign a_msb    = a_dr[2*W-1];
  assign bp_msb   = b_dr[2*W-1] ^ sub;
  assign res_msb  = res_dr[2*W-1];

  assign v_flag = arith_en & (a_msb == bp_msb) & (res_msb != a_msb);
  assign n_flag = res_msb;
  assign z_flag = ~|res_true;

  assign capture  = (state_q == S_DATA) && data_complete && ki;
  assign null_ret = (state_q == S_NULL) && null_complete && !ki;

  // Counter/sticky next state; clr takes priority over a coincident capture.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (capture && v_flag) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_DATA;
      ko_q     <= 1'b1;
      flags_q  <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      ill_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      if (any_ill) begin
        ill_q <= 1'b1;
      end
      case (state_q)
        S_DATA: begin
          if (capture) begin
            flags_q <= {v_flag, ~v_flag, n_flag, ~n_flag, z_flag, ~z_flag};
            ko_q    <= 1'b0;
            state_q <= S_NULL;
          end
        end
        S_NULL: begin
          if (null_ret) begin
            flags_q <= '0;
            ko_q    <= 1'b1;
            state_q <= S_DATA;
          end
        end
        default: begin
          state_q <= S_DATA;
          ko_q    <= 1'b1;
          flags_q <= '0;
        end
      endcase
    end
  end

  assign ko          = ko_q;
  assign flags_dr    = flags_q;
  assign ovf_sticky  = sticky_q;
  assign ovf_cnt     = cnt_q;
  assign illegal_err = ill_q;

endmodule

// File: tb/tb_ncl_flag_unit.sv
// Scoreboard bench for ncl_flag_unit. Two instances share the same stimulus:
// one with the default 8-bit counter and one with a 2-bit counter so that
// saturation is exercised. Every handshake transition (ko edge) is matched
// against an expectation pushed by the stimulus process.
module tb_ncl_flag_unit;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*W-1:0] a_dr, b_dr, res_dr;
  logic [3:0]     op_dr;
  logic           ki, clr;

  logic           ko8, ko2;
  logic [5:0]     flags8, flags2;
  logic           sticky8, sticky2;
  logic [7:0]     cnt8;
  logic [1:0]     cnt2;
  logic           ill8, ill2;

  always #5 clk = ~clk;

  ncl_flag_unit #(.W(W), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .a_dr(a_dr), .b_dr(b_dr), .res_dr(res_dr),
    .op_dr(op_dr), .ki(ki), .clr(clr), .ko(ko8), .flags_dr(flags8),
    .ovf_sticky(sticky8), .ovf_cnt(cnt8), .illegal_err(ill8)
  );

  ncl_flag_unit #(.W(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a_dr(a_dr), .b_dr(b_dr), .res_dr(res_dr),
    .op_dr(op_dr), .ki(ki), .clr(clr), .ko(ko2), .flags_dr(flags2),
    .ovf_sticky(sticky2), .ovf_cnt(cnt2), .illegal_err(ill2)
  );

  typedef struct {
    logic       ko;
    logic [5:0] flags;
    logic       sticky;
    int         c8;
    int         c2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  // reference model state
  bit m_sticky;
  int m_c8, m_c2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [2*W-1:0] enc(input int v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i +: 2] = ((v >> i) & 1) ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [1:0] enc1(input bit b);
    return b ? 2'b10 : 2'b01;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go_null();
    a_dr = '0; b_dr = '0; res_dr = '0; op_dr = '0;
  endtask

  // Present a correct ALU result for A op B; expectation from signed arithmetic.
  task automatic capture(input int a, input int b, input bit sub, input bit aen, input bit clr_v);
    int sa, sb, r, res;
    bit v, n, z;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    r   = sub ? sa - sb : sa + sb;
    res = r & 255;
    v   = aen && (r > 127 || r < -128);
    n   = (res >= 128);
    z   = (res == 0);
    a_dr = enc(a); b_dr = enc(b); res_dr = enc(res);
    op_dr = {enc1(aen), enc1(sub)};
    ki = 1'b1; clr = clr_v;
    if (clr_v) begin
      m_sticky = 0; m_c8 = 0; m_c2 = 0;
    end else if (v) begin
      m_sticky = 1;
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3) m_c2++;
    end
    exp_q.push_back('{1'b0, {enc1(v), enc1(n), enc1(z)}, m_sticky, m_c8, m_c2});
    cycle();
    clr = 1'b0;
  endtask

  task automatic release_null();
    go_null();
    ki = 1'b0;
    exp_q.push_back('{1'b1, 6'b0, m_sticky, m_c8, m_c2});
    cycle();
  endtask

  // Monitor: every ko transition is a DUT response; pop and compare.
  initial begin
    logic prev;
    exp_t e;
    wait (mon_en);
    prev = ko8;
    forever begin
      @(negedge clk);
      if (ko8 !== prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ko_edge: got ko=%0b expected no transition", ko8);
        end else begin
          e = exp_q.pop_front();
          $display("txn t=%0t ko=%0b flags=%b sticky=%0b cnt8=%0d cnt2=%0d",
                   $time, ko8, flags8, sticky8, cnt8, cnt2);
          chk("ko", 32'(ko8), 32'(e.ko));
          chk("ko_w2", 32'(ko2), 32'(e.ko));
          chk("flags", 32'(flags8), 32'(e.flags));
          chk("flags_w2", 32'(flags2), 32'(e.flags));
          chk("sticky", 32'(sticky8), 32'(e.sticky));
          chk("sticky_w2", 32'(sticky2), 32'(e.sticky));
          chk("cnt8", 32'(cnt8), 32'(e.c8));
          chk("cnt2", 32'(cnt2), 32'(e.c2));
        end
        prev = ko8;
      end
    end
  end

  initial begin
    rst = 1'b1; ki = 1'b0; clr = 1'b0;
    go_null();
    m_sticky = 0; m_c8 = 0; m_c2 = 0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("reset_ko", 32'(ko8), 32'd1);
    chk("reset_flags", 32'(flags8), 32'd0);
    chk("reset_sticky", 32'(sticky8), 32'd0);
    chk("reset_cnt", 32'(cnt8), 32'd0);
    chk("reset_ill", 32'(ill8), 32'd0);
    mon_en = 1;
    @(negedge clk); #1;

    // add overflow, sub overflow, sub to zero, arith disabled
    capture(8'h7F, 8'h01, 0, 1, 0); release_null();
    capture(8'h80, 8'h01, 1, 1, 0); release_null();
    capture(8'h05, 8'h05, 1, 1, 0); release_null();
    capture(8'h7F, 8'h01, 0, 0, 0); release_null();

    // DATA-complete but ki=0: no capture for 5 cycles
    a_dr = enc(8'h10); b_dr = enc(8'h20); res_dr = enc(8'h30);
    op_dr = {enc1(1), enc1(0)}; ki = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("ki0_hold_ko", 32'(ko8), 32'd1);
      chk("ki0_hold_flags", 32'(flags8), 32'd0);
    end
    capture(8'h10, 8'h20, 0, 1, 0); release_null();

    // partial wavefront: result still NULL
    a_dr = enc(8'h33); b_dr = enc(8'h44); res_dr = '0;
    op_dr = {enc1(1), enc1(0)}; ki = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("partial_ko", 32'(ko8), 32'd1);
    end

    // illegal 11 on a_dr logical bit 3
    chk("ill_before", 32'(ill8), 32'd0);
    a_dr = enc(8'h33); a_dr[7:6] = 2'b11; res_dr = enc(8'h77);
    cycle();
    chk("ill_set", 32'(ill8), 32'd1);
    chk("ill_set_w2", 32'(ill2), 32'd1);
    chk("ill_no_capture", 32'(ko8), 32'd1);
    go_null(); ki = 1'b0; clr = 1'b1;
    m_sticky = 0; m_c8 = 0; m_c2 = 0;
    cycle();
    clr = 1'b0;
    chk("ill_survives_clr", 32'(ill8), 32'd1);
    chk("clr_cnt", 32'(cnt8), 32'd0);
    chk("clr_sticky", 32'(sticky8), 32'd0);

    // saturation of the 2-bit counter, then clr wins over a V capture
    for (int i = 0; i < 4; i++) begin
      capture(8'h7F, 8'h01, 0, 1, 0); release_null();
    end
    capture(8'h7F, 8'h01, 0, 1, 1); release_null();

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      capture(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
              bit'($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) cycle();
      release_null();
    end

    // reset while in S_NULL with DATA flags shown
    capture(8'h7F, 8'h01, 0, 1, 0);
    a_dr = enc(int'($urandom_range(0, 255))); ki = bit'($urandom_range(0, 1));
    rst = 1'b1;
    m_sticky = 0; m_c8 = 0; m_c2 = 0;
    exp_q.push_back('{1'b1, 6'b0, 1'b0, 0, 0});
    cycle();
    rst = 1'b0;
    go_null(); ki = 1'b0;
    chk("rst_ill", 32'(ill8), 32'd0);
    chk("rst_ko", 32'(ko8), 32'd1);

    repeat (3) cycle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
